// File: rtl/core_arbiter.sv
// Two-master to one-slave core-bus arbiter: round-robin with request locking,
// plus an in-order ID FIFO that routes each slave response back to its issuer.
module core_arbiter #(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   input  logic        m0_we,
   input  logic [3:0]  m0_be,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   input  logic        m1_we,
   input  logic [3:0]  m1_be,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        s_req,
   input  logic        s_gnt,
   input  logic        s_rvalid,
   output logic        s_we,
   output logic [3:0]  s_be,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   input  logic        s_err,
   output logic        protocol_err
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

   logic                       r_locked;
   logic                       r_lockId;
   logic                       r_last;
   logic                       r_protocolErr;
   logic [CW-1:0]              r_count;
   logic [PW-1:0]              r_wrPtr;
   logic [PW-1:0]              r_rdPtr;
   logic [MAX_OUTSTANDING-1:0] r_idFifo;

   logic w_sel;
   logic w_selReq;
   logic w_sReq;
   logic w_handshake;
   logic w_pop;
   logic w_head;

   // A locked request keeps the bus; otherwise a lone requester wins and a tie goes to ~last.
   always_comb begin
      w_sel = 1'b0;
      if (r_locked)
         w_sel = r_lockId;
      else if (m0_req && !m1_req)
         w_sel = 1'b0;
      else if (m1_req && !m0_req)
         w_sel = 1'b1;
      else if (m0_req && m1_req)
         w_sel = ~r_last;
   end

   // Full-blocking looks at the registered count, so a same-cycle pop never frees a slot early.
   assign w_selReq    = w_sel ? m1_req : m0_req;
   assign w_sReq      = !rst && w_selReq && (r_count < MAX_CNT);
   assign w_handshake = w_sReq && s_gnt;
   assign w_pop       = !rst && s_rvalid && (r_count != '0);
   assign w_head      = r_idFifo[r_rdPtr];

   always_comb begin
      s_req     = w_sReq;
      s_we      = 1'b0;
      s_be      = 4'h0;
      s_addr    = 32'h0;
      s_wdata   = 32'h0;
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      m0_rvalid = 1'b0;
      m0_rdata  = 32'h0;
      m0_err    = 1'b0;
      m1_rvalid = 1'b0;
      m1_rdata  = 32'h0;
      m1_err    = 1'b0;
      if (w_sReq) begin
         s_we    = w_sel ? m1_we    : m0_we;
         s_be    = w_sel ? m1_be    : m0_be;
         s_addr  = w_sel ? m1_addr  : m0_addr;
         s_wdata = w_sel ? m1_wdata : m0_wdata;
         m0_gnt  = s_gnt && !w_sel;
         m1_gnt  = s_gnt && w_sel;
      end
      if (w_pop) begin
         if (w_head) begin
            m1_rvalid = 1'b1;
            m1_rdata  = s_rdata;
            m1_err    = s_err;
         end else begin
            m0_rvalid = 1'b1;
            m0_rdata  = s_rdata;
            m0_err    = s_err;
         end
      end
   end

   assign protocol_err = r_protocolErr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_locked      <= 1'b0;
         r_lockId      <= 1'b0;
         r_last        <= 1'b1;
         r_protocolErr <= 1'b0;
         r_count       <= '0;
         r_wrPtr       <= '0;
         r_rdPtr       <= '0;
         r_idFifo      <= '0;
      end else begin
         if (w_handshake) begin
            r_locked          <= 1'b0;
            r_last            <= w_sel;
            r_idFifo[r_wrPtr] <= w_sel;
            r_wrPtr           <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + 1'b1;
         end else if (w_sReq) begin
            r_locked <= 1'b1;
            r_lockId <= w_sel;
         end
         if (w_pop)
            r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + 1'b1;
         case ({w_handshake, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (s_rvalid && (r_count == '0))
            r_protocolErr <= 1'b1;
      end
   end

endmodule
